// File: rtl/alphabet_nibble_encoder_pkg.sv
// Shared definitions for the alphabet-set multiplier encoder: select codes,
// FSM state encoding and the helpers that size the nibble index.
package alphabet_nibble_encoder_pkg;

    // Alphabet select codes. They pick one of the precomputed multiplicand
    // bank outputs (1x, 3x, 5x, 7x) in the downstream datapath.
    localparam logic [1:0] SEL_1X = 2'b00;
    localparam logic [1:0] SEL_3X = 2'b01;
    localparam logic [1:0] SEL_5X = 2'b10;
    localparam logic [1:0] SEL_7X = 2'b11;

    // Encoder FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,   // waiting for an operand
        ST_EMIT = 1'b1    // streaming encoded beats
    } state_t;

    // Beats per operand: one per nibble.
    function automatic int num_nibbles(input int log2_width, input int log2_nibble_width);
        return 1 << (log2_width - log2_nibble_width);
    endfunction

    // Width of the nibble index; kept at least one bit so a single-nibble
    // operand still has a legal index port.
    function automatic int idx_width(input int log2_width, input int log2_nibble_width);
        return ((log2_width - log2_nibble_width) < 1) ? 1 : (log2_width - log2_nibble_width);
    endfunction

endpackage

// File: rtl/alphabet_nibble_encoder_lut.sv
// Nibble-to-alphabet encoder. Maps a 4-bit multiplier nibble onto an odd
// alphabet member {1,3,5,7} times a power of two. Nibbles 9, 11, 13 and 15
// have an odd part above 7 and are replaced by the nearest reachable value
// (flagged with approx). Purely combinational.
module nibble_alphabet_lut
    import alphabet_nibble_encoder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [1:0] sel,
    output logic [1:0] shift,
    output logic       zero,
    output logic       approx
);

    // Table lookup of (select, shift, zero, approx) for every nibble value.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        sel    = SEL_1X;
        shift  = 2'd0;
        zero   = 1'b0;
        approx = 1'b0;
        unique case (nibble)
            4'd0:  zero = 1'b1;                                    // partial product is 0
            4'd1:  begin sel = SEL_1X; shift = 2'd0; end           // 1
            4'd2:  begin sel = SEL_1X; shift = 2'd1; end           // 1<<1
            4'd3:  begin sel = SEL_3X; shift = 2'd0; end           // 3
            4'd4:  begin sel = SEL_1X; shift = 2'd2; end           // 1<<2
            4'd5:  begin sel = SEL_5X; shift = 2'd0; end           // 5
            4'd6:  begin sel = SEL_3X; shift = 2'd1; end           // 3<<1
            4'd7:  begin sel = SEL_7X; shift = 2'd0; end           // 7
            4'd8:  begin sel = SEL_1X; shift = 2'd3; end           // 1<<3
            4'd9:  begin sel = SEL_1X; shift = 2'd3; approx = 1'b1; end  // 9  ~ 8
            4'd10: begin sel = SEL_5X; shift = 2'd1; end           // 5<<1
            4'd11: begin sel = SEL_3X; shift = 2'd2; approx = 1'b1; end  // 11 ~ 12
            4'd12: begin sel = SEL_3X; shift = 2'd2; end           // 3<<2
            4'd13: begin sel = SEL_3X; shift = 2'd2; approx = 1'b1; end  // 13 ~ 12
            4'd14: begin sel = SEL_7X; shift = 2'd1; end           // 7<<1
            4'd15: begin sel = SEL_7X; shift = 2'd1; approx = 1'b1; end  // 15 ~ 14
            default: ;
        endcase
    end

endmodule

// File: rtl/alphabet_nibble_encoder.sv
// Multiplier-side encoder for the alphabet-set multiplier. Accepts one
// operand over valid/ready, then streams one encoded beat per nibble, LSB
// nibble first. A new operand may be accepted on the last beat so that
// consecutive operands stream with no bubble.
module alphabet_nibble_encoder
    import alphabet_nibble_encoder_pkg::*;
#(
    parameter int LOG2_WIDTH        = 4,
    parameter int WIDTH             = 2 ** LOG2_WIDTH,
    parameter int LOG2_NIBBLE_WIDTH = 2,
    parameter int NIBBLE_WIDTH      = 2 ** LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = num_nibbles(LOG2_WIDTH, LOG2_NIBBLE_WIDTH),
    parameter int LOG2_NUM_NIBBLES  = idx_width(LOG2_WIDTH, LOG2_NIBBLE_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LOG2_NIBBLE_WIDTH-1:0] out_sel,
    output logic [LOG2_NIBBLE_WIDTH-1:0] out_shift,
    output logic                         out_zero,
    output logic                         out_approx,
    output logic [LOG2_NUM_NIBBLES-1:0]  out_idx,
    output logic                         out_last
);

    localparam logic [LOG2_NUM_NIBBLES-1:0] LAST_IDX = LOG2_NUM_NIBBLES'(NUM_NIBBLES - 1);

    state_t                        state, state_next;
    logic [WIDTH-1:0]              operand, operand_next;
    logic [LOG2_NUM_NIBBLES-1:0]   idx, idx_next;
    logic [NIBBLE_WIDTH-1:0]       nibble;

    // Beat fields depend only on the registered operand and index, so they
    // cannot move while a beat is stalled.
    assign nibble   = operand[idx*NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign out_idx  = idx;
    assign out_last = (idx == LAST_IDX);

    nibble_alphabet_lut u_lut (
        .nibble (nibble),
        .sel    (out_sel),
        .shift  (out_shift),
        .zero   (out_zero),
        .approx (out_approx)
    );

    // Next-state, handshake and operand/index update logic.
    always_comb begin
        state_next   = state;
        operand_next = operand;
        idx_next     = idx;
        out_valid    = 1'b0;
        in_ready     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next   = ST_EMIT;
                    operand_next = in_data;
                    idx_next     = '0;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                // NOTE: in_ready follows out_ready combinationally on the last
                // beat; this is what lets the next operand load with no bubble.
                in_ready  = out_last && out_ready;
                if (out_ready) begin
                    if (!out_last) begin
                        idx_next = idx + LOG2_NUM_NIBBLES'(1);
                    end else if (in_valid) begin
                        operand_next = in_data;
                        idx_next     = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, operand and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= ST_IDLE;
            operand <= '0;
            idx     <= '0;
        end else begin
            state   <= state_next;
            operand <= operand_next;
            idx     <= idx_next;
        end
    end

endmodule

// File: tb/tb_alphabet_nibble_encoder.sv
// Directed bench for alphabet_nibble_encoder. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_alphabet_nibble_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
    logic [1:0]  out_shift;
    logic        out_zero;
    logic        out_approx;
    logic [1:0]  out_idx;
    logic        out_last;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alphabet_nibble_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_approx (out_approx),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Check every field of a valid beat for nibble i.
    task automatic check_beat(input string tag, input int i, input logic [1:0] sel,
                              input logic [1:0] shift, input logic zero,
                              input logic approx, input logic rdy);
        check($sformatf("%s b%0d valid", tag, i), 32'(out_valid), 32'd1);
        check($sformatf("%s b%0d sel", tag, i), 32'(out_sel), 32'(sel));
        check($sformatf("%s b%0d shift", tag, i), 32'(out_shift), 32'(shift));
        check($sformatf("%s b%0d zero", tag, i), 32'(out_zero), 32'(zero));
        check($sformatf("%s b%0d approx", tag, i), 32'(out_approx), 32'(approx));
        check($sformatf("%s b%0d idx", tag, i), 32'(out_idx), 32'(i));
        check($sformatf("%s b%0d last", tag, i), 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
        check($sformatf("%s b%0d in_ready", tag, i), 32'(in_ready), 32'(rdy));
    endtask

    // Present an operand while the encoder is idle; it is captured on the next rising edge.
    task automatic offer(input string tag, input logic [15:0] data);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b1;
        #1;
        check({tag, " offer in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " offer out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Walk the four beats of the current operand. stalls holds a 2-bit stall
    // count per beat; nv/nd is what in_valid/in_data show during the beats.
    task automatic run_beats(input string tag, input logic [7:0] sel, input logic [7:0] shift,
                             input logic [3:0] zero, input logic [3:0] approx,
                             input logic [7:0] stalls, input logic nv, input logic [15:0] nd);
        for (int i = 0; i < 4; i++) begin
            int s;
            s = int'(stalls[2*i +: 2]);
            for (int k = 0; k <= s; k++) begin
                @(negedge clk);
                in_valid  = nv;
                in_data   = nd;
                out_ready = (k == s);
                #1;
                check_beat(tag, i, sel[2*i +: 2], shift[2*i +: 2], zero[i], approx[i],
                           (i == 3) && (k == s));
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset sel", 32'(out_sel), 32'd0);
        check("reset shift", 32'(out_shift), 32'd0);
        check("reset zero", 32'(out_zero), 32'd1);
        check("reset approx", 32'(out_approx), 32'd0);
        check("reset idx", 32'(out_idx), 32'd0);
        check("reset last", 32'(out_last), 32'd0);

        // All-zero operand: every beat is a zero partial product.
        offer("z0000", 16'h0000);
        run_beats("z0000", 8'h00, 8'h00, 4'hF, 4'h0, 8'h00, 1'b0, 16'h0000);
        idle_check("z0000");

        // Nibbles 1,3,5,7: each alphabet member exactly, no shift.
        offer("x7531", 16'h7531);
        run_beats("x7531", 8'b11_10_01_00, 8'h00, 4'h0, 4'h0, 8'h00, 1'b0, 16'h0000);
        idle_check("x7531");

        // Nibbles 9,B,D,F: every approximated value.
        offer("xFDB9", 16'hFDB9);
        run_beats("xFDB9", 8'b11_01_01_00, 8'b01_10_10_11, 4'h0, 4'hF, 8'h00, 1'b0, 16'h0000);
        idle_check("xFDB9");

        // Nibbles 2,4,6,8 with stalls of 0,2,1,1 cycles on the four beats.
        offer("x8642", 16'h8642);
        run_beats("x8642", 8'b00_01_00_00, 8'b11_01_10_01, 4'h0, 4'h0, 8'b01_01_10_00,
                  1'b0, 16'h0000);
        idle_check("x8642");

        // Back-to-back: the second operand is held from the first beat and
        // must only be taken on the first operand's last beat.
        offer("b2bA", 16'h7531);
        run_beats("b2bA", 8'b11_10_01_00, 8'h00, 4'h0, 4'h0, 8'h00, 1'b1, 16'hFDB9);
        run_beats("b2bB", 8'b11_01_01_00, 8'b01_10_10_11, 4'h0, 4'hF, 8'h00, 1'b0, 16'h0000);
        idle_check("b2b");

        // Reset while the third beat is pending.
        offer("rst", 16'h7531);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            check($sformatf("rst pre b%0d idx", i), 32'(out_idx), 32'(i));
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("rst pre idx2", 32'(out_idx), 32'd2);
        check("rst pre sel", 32'(out_sel), 32'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst post out_valid", 32'(out_valid), 32'd0);
        check("rst post in_ready", 32'(in_ready), 32'd1);
        check("rst post idx", 32'(out_idx), 32'd0);
        check("rst post zero", 32'(out_zero), 32'd1);
        offer("rstnew", 16'h8642);
        run_beats("rstnew", 8'b00_01_00_00, 8'b11_01_10_01, 4'h0, 4'h0, 8'h00, 1'b0, 16'h0000);
        idle_check("rstnew");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
